// File: rtl/apb_slave_mem.sv
// APB slave backed by a small word-addressed memory, with a configurable
// number of wait states, error response for misaligned or out-of-range
// addresses, and a sticky protocol-violation flag.
module apb_slave_mem #(
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic [32:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        proto_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [32:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] prdata_q;
  logic        proto_err_q;
  logic [31:0] mem_q [DEPTH];

  logic              setupErr;
  logic              capErr;
  logic [ADDR_W-1:0] setupIdx;
  logic [ADDR_W-1:0] capIdx;
  logic              busChanged;

  // A byte address is bad if it is not word aligned or lies above the
  // memory; bit 32 never takes part because the master already decoded it.
  function automatic logic addrErr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:ADDR_W+2] != '0);
  endfunction

  assign setupErr   = addrErr(paddr[31:0]);
  assign capErr     = addrErr(addr_q[31:0]);
  assign setupIdx   = paddr[ADDR_W+1:2];
  assign capIdx     = addr_q[ADDR_W+1:2];
  assign busChanged = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);

  // Transfer FSM, wait-state counter, registered APB outputs and memory.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (psel && penable) begin
            proto_err_q <= 1'b1;
          end else if (psel) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            cnt_q   <= CNT_INIT;
            state_q <= ACCESS;
            if (WAIT_CYCLES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= setupErr;
              if (!pwrite) begin
                prdata_q <= setupErr ? 32'h0 : mem_q[setupIdx];
              end
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
          end else begin
            if (busChanged) begin
              proto_err_q <= 1'b1;
            end
            if (penable) begin
              if (pready_q) begin
                if (write_q && !capErr) begin
                  mem_q[capIdx] <= wdata_q;
                end
                pready_q  <= 1'b0;
                pslverr_q <= 1'b0;
                state_q   <= IDLE;
              end else if (cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                  pready_q  <= 1'b1;
                  pslverr_q <= capErr;
                  if (!write_q) begin
                    prdata_q <= capErr ? 32'h0 : mem_q[capIdx];
                  end
                end
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: instance 0 runs with two wait states,
// instance 1 with none. The driver pushes expected responses computed from
// a plain array model; a monitor pops and compares whenever pready shows.
module tb_apb_slave_mem;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
  } exp_t;

  logic             pclk;
  logic [1:0]       preset;
  logic [1:0]       psel;
  logic [1:0]       penable;
  logic [1:0][32:0] paddr;
  logic [1:0]       pwrite;
  logic [1:0][31:0] pwdata;
  wire  [1:0]       pready;
  wire  [1:0][31:0] prdata;
  wire  [1:0]       pslverr;
  wire  [1:0]       proto_err;

  int checks = 0;
  int errors = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model[2][16];
  logic [31:0] lastRd[2];

  for (genvar g = 0; g < 2; g++) begin : gDut
    apb_slave_mem #(
      .ADDR_W(4),
      .WAIT_CYCLES(g == 0 ? 2 : 0)
    ) dut (
      .pclk(pclk),
      .preset(preset[g]),
      .psel(psel[g]),
      .penable(penable[g]),
      .paddr(paddr[g]),
      .pwrite(pwrite[g]),
      .pwdata(pwdata[g]),
      .pready(pready[g]),
      .prdata(prdata[g]),
      .pslverr(pslverr[g]),
      .proto_err(proto_err[g])
    );
  end

  // Free-running clock, 10 time units per period.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic int waitOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Mostly in-range aligned addresses, with some misaligned and some beyond
  // the 64-byte window; bit 32 is random since the slave must ignore it.
  function automatic logic [32:0] randAddr();
    logic [32:0] a;
    case ($urandom_range(0, 9))
      0:       a[31:0] = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      1:       a[31:0] = ($urandom() & 32'hFFFF_FFFC) | 32'h0000_0040;
      default: a[31:0] = 32'($urandom_range(0, 15) * 4);
    endcase
    a[32] = 1'($urandom_range(0, 1));
    return a;
  endfunction

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge pclk);
      #1;
    end
  endtask

  // One APB transfer starting right now (just after a rising edge). A
  // non-zero abortAfter drops psel after that many access cycles and
  // expects no response. Returns just after the completion edge.
  task automatic applyStimulus(input int d, input bit wr, input logic [32:0] addr,
                               input logic [31:0] data, input int abortAfter);
    exp_t e;
    bit   bad;
    int   idx;
    int   n;
    bit   done;
    bad = (addr[1:0] != 2'b00) || (addr[31:0] >= 32'd64);
    idx = int'(addr[31:0] / 4) % 16;
    if (abortAfter == 0) begin
      if (wr) begin
        e.rdata = lastRd[d];
        if (!bad) model[d][idx] = data;
      end else begin
        e.rdata   = bad ? 32'h0 : model[d][idx];
        lastRd[d] = e.rdata;
      end
      e.slverr = bad;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    paddr[d]   = addr;
    pwrite[d]  = wr;
    pwdata[d]  = data;
    @(posedge pclk);
    #1;
    penable[d] = 1'b1;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge pclk);
      n++;
      if (pready[d] === 1'b1) begin
        checkOutput($sformatf("dut%0d access cycles to pready", d), 32'(n), 32'(waitOf(d) + 1));
        done = 1'b1;
      end else if (abortAfter != 0 && n >= abortAfter) begin
        done = 1'b1;
      end else if (n >= 40) begin
        checks++;
        errors++;
        $display("[TB] FAIL dut%0d pready timeout: got none after %0d cycles, expected at %0d", d, n, waitOf(d) + 1);
        done = 1'b1;
      end
      @(posedge pclk);
      #1;
    end
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
  endtask

  // Monitor: every cycle pready is high must match the oldest expected response.
  always @(negedge pclk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (preset[d] === 1'b1 && pready[d] === 1'b1) begin
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
          checks++;
          errors++;
          $display("[TB] FAIL dut%0d unexpected pready: got 1, expected 0", d);
        end else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          checkOutput($sformatf("dut%0d prdata", d), prdata[d], e.rdata);
          checkOutput($sformatf("dut%0d pslverr", d), 32'(pslverr[d]), 32'(e.slverr));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    preset  = '0;
    psel    = '0;
    penable = '0;
    paddr   = '0;
    pwrite  = '0;
    pwdata  = '0;
    for (int d = 0; d < 2; d++) begin
      lastRd[d] = 32'h0;
      for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
    end
    repeat (3) @(posedge pclk);
    #1;
    preset = '1;
    @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d reset pready", d), 32'(pready[d]), 32'h0);
      checkOutput($sformatf("dut%0d reset pslverr", d), 32'(pslverr[d]), 32'h0);
      checkOutput($sformatf("dut%0d reset prdata", d), prdata[d], 32'h0);
      checkOutput($sformatf("dut%0d reset proto_err", d), 32'(proto_err[d]), 32'h0);
    end
    @(posedge pclk);
    #1;

    $display("[TB] two wait states: abort, directed and error accesses");
    applyStimulus(0, 1'b1, 33'h00C, 32'h1234_5678, 1);
    idle(3);
    applyStimulus(0, 1'b0, 33'h00C, 32'h0, 0);
    applyStimulus(0, 1'b1, 33'h008, 32'hDEAD_BEEF, 0);
    applyStimulus(0, 1'b0, 33'h008, 32'h0, 0);
    applyStimulus(0, 1'b1, 33'h004, 32'h5555_AAAA, 0);
    applyStimulus(0, 1'b0, 33'h040, 32'h0, 0);
    applyStimulus(0, 1'b1, 33'h006, 32'hFFFF_FFFF, 0);
    applyStimulus(0, 1'b0, 33'h004, 32'h0, 0);
    applyStimulus(0, 1'b0, 33'h1_0000_0008, 32'h0, 0);

    $display("[TB] no wait states: back-to-back accesses");
    applyStimulus(1, 1'b1, 33'h000, 32'hA5A5_0001, 0);
    applyStimulus(1, 1'b1, 33'h004, 32'h5A5A_0002, 0);
    applyStimulus(1, 1'b0, 33'h000, 32'h0, 0);
    applyStimulus(1, 1'b0, 33'h004, 32'h0, 0);
    applyStimulus(1, 1'b0, 33'h06C, 32'h0, 0);

    $display("[TB] randomized traffic");
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        applyStimulus(d, 1'($urandom_range(0, 1)), randAddr(), $urandom(), 0);
        idle($urandom_range(0, 2));
      end
      @(negedge pclk);
      checkOutput($sformatf("dut%0d proto_err after clean traffic", d), 32'(proto_err[d]), 32'h0);
      @(posedge pclk);
      #1;
    end

    $display("[TB] access without setup");
    psel[0]    = 1'b1;
    penable[0] = 1'b1;
    paddr[0]   = 33'h010;
    pwrite[0]  = 1'b0;
    @(posedge pclk);
    #1;
    psel[0]    = 1'b0;
    penable[0] = 1'b0;
    @(negedge pclk);
    checkOutput("dut0 proto_err set", 32'(proto_err[0]), 32'h1);
    idle(3);
    @(negedge pclk);
    checkOutput("dut0 proto_err sticky", 32'(proto_err[0]), 32'h1);
    @(posedge pclk);
    #1;
    applyStimulus(0, 1'b1, 33'h008, 32'h0BAD_F00D, 0);
    applyStimulus(0, 1'b0, 33'h008, 32'h0, 0);

    $display("[TB] reset during a wait cycle");
    psel[0]    = 1'b1;
    penable[0] = 1'b0;
    paddr[0]   = 33'h008;
    pwrite[0]  = 1'b1;
    pwdata[0]  = 32'hCAFE_F00D;
    @(posedge pclk);
    #1;
    penable[0] = 1'b1;
    @(posedge pclk);
    #3;
    preset[0] = 1'b0;
    #1;
    checkOutput("dut0 async reset pready", 32'(pready[0]), 32'h0);
    checkOutput("dut0 async reset pslverr", 32'(pslverr[0]), 32'h0);
    checkOutput("dut0 async reset prdata", prdata[0], 32'h0);
    checkOutput("dut0 async reset proto_err", 32'(proto_err[0]), 32'h0);
    psel[0]    = 1'b0;
    penable[0] = 1'b0;
    for (int i = 0; i < 16; i++) model[0][i] = 32'h0;
    lastRd[0] = 32'h0;
    @(posedge pclk);
    #1;
    preset[0] = 1'b1;
    @(posedge pclk);
    #1;
    applyStimulus(0, 1'b0, 33'h008, 32'h0, 0);
    applyStimulus(0, 1'b0, 33'h004, 32'h0, 0);
    applyStimulus(0, 1'b0, 33'h03C, 32'h0, 0);

    idle(3);
    checkOutput("dut0 responses outstanding", 32'(q0.size()), 32'h0);
    checkOutput("dut1 responses outstanding", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
